pipe_stall_ctrl: RTL

//  Pipeline hazard/stall controller for the 5-stage core; replaces the constant NoStop stallreq from decode.

---
 rtl/pipe_stall_ctrl_pkg.sv | 38 +++
 rtl/pipe_stall_ctrl_mc_seq.sv | 85 ++++++++
 rtl/pipe_stall_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall masks, multi-cycle
// sequencer states and the set of load aluops that can cause a load-use hazard.
package pipe_stall_ctrl_pkg;

    localparam int STALL_W = 6;

    // Stall bits: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb
    localparam logic [STALL_W-1:0] STALL_NONE      = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF_MASK   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_LOAD_MASK = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_MC_MASK   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM_MASK  = 6'b011111;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_RUN  = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

    localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
    localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
    localparam logic [7:0] EXE_LWL_OP = 8'b11100010;
    localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
    localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
    localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
    localparam logic [7:0] EXE_LWR_OP = 8'b11100110;

    function automatic logic is_load_op(input logic [7:0] op);
        logic hit;
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
            EXE_LW_OP, EXE_LWL_OP, EXE_LWR_OP: hit = 1'b1;
            default:                           hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_mc_seq.sv
// Multi-cycle EX op sequencer: IDLE -> MC_RUN -> MC_DONE with a down-counter,
// cancel to IDLE from any state, and MC_DONE held while the memory stage stalls.
module pipe_stall_ctrl_mc_seq
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MC_CNT_W-1:0] cycles,
    input  logic                cancel,
    input  logic                hold,
    output logic                accept,
    output logic                busy,
    output logic                done
);

    localparam logic [MC_CNT_W-1:0] CNT_ONE = {{(MC_CNT_W-1){1'b0}}, 1'b1};

    mc_state_t           state_reg, state_next;
    logic [MC_CNT_W-1:0] cnt_reg, cnt_next;
    logic [MC_CNT_W-1:0] op_len;

    // A zero-length op still needs one cycle for the result to appear.
    assign op_len = (cycles == '0) ? CNT_ONE : cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= MC_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The start cycle itself counts as the first op cycle, so the counter holds
    // the cycles remaining after it; done then lands exactly op_len cycles later.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        if (cancel) begin
            state_next = MC_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                MC_IDLE: begin
                    if (start) begin
                        accept = 1'b1;
                        if (op_len == CNT_ONE) begin
                            state_next = MC_DONE;
                            cnt_next   = '0;
                        end else begin
                            state_next = MC_RUN;
                            cnt_next   = op_len - CNT_ONE;
                        end
                    end
                end
                MC_RUN: begin
                    if (cnt_reg <= CNT_ONE) begin
                        state_next = MC_DONE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end
                MC_DONE: begin
                    if (!hold) begin
                        state_next = MC_IDLE;
                    end
                end
                default: begin
                    state_next = MC_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign busy = (state_reg == MC_RUN);
    assign done = (state_reg == MC_DONE);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use detection, multi-cycle op sequencing
// and stall-vector merge. Optional stall-cycle counter enabled by STALL_PERF_CNT_EN.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_reg1_read,
    input  logic [4:0]          id_reg1_addr,
    input  logic                id_reg2_read,
    input  logic [4:0]          id_reg2_addr,
    input  logic [7:0]          ex_aluop,
    input  logic                ex_wreg,
    input  logic [4:0]          ex_wd,
    input  logic                ex_mc_start,
    input  logic [MC_CNT_W-1:0] ex_mc_cycles,
    input  logic                mc_cancel,
    input  logic                stallreq_if,
    input  logic                stallreq_mem,
    output logic [5:0]          stall_o,
    output logic                load_stall_o,
    output logic                mc_busy_o,
    output logic                mc_done_o,
    output logic [PERF_W-1:0]   stall_cycles_o
);

    logic               load_hazard;
    logic               mc_accept;
    logic               mc_busy;
    logic               mc_done;
    logic               mc_stall;
    logic [STALL_W-1:0] src_mask [4];
    logic [STALL_W-1:0] stall_merged;

    pipe_stall_ctrl_mc_seq #(
        .MC_CNT_W (MC_CNT_W)
    ) u_mc_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (ex_mc_start),
        .cycles (ex_mc_cycles),
        .cancel (mc_cancel),
        .hold   (stallreq_mem),
        .accept (mc_accept),
        .busy   (mc_busy),
        .done   (mc_done)
    );

    // $0 is never a real dependency, so a load targeting it cannot cause a hazard.
    assign load_hazard = is_load_op(ex_aluop) && ex_wreg && (ex_wd != 5'd0) &&
                         ((id_reg1_read && (id_reg1_addr == ex_wd)) ||
                          (id_reg2_read && (id_reg2_addr == ex_wd)));

    assign mc_stall = mc_accept || mc_busy;

    assign src_mask[0] = stallreq_mem ? STALL_MEM_MASK  : STALL_NONE;
    assign src_mask[1] = mc_stall     ? STALL_MC_MASK   : STALL_NONE;
    assign src_mask[2] = load_hazard  ? STALL_LOAD_MASK : STALL_NONE;
    assign src_mask[3] = stallreq_if  ? STALL_IF_MASK   : STALL_NONE;

    genvar gi;
    generate
        for (gi = 0; gi < STALL_W; gi++) begin : g_merge
            assign stall_merged[gi] = src_mask[0][gi] | src_mask[1][gi] |
                                      src_mask[2][gi] | src_mask[3][gi];
        end
    endgenerate

    // Outputs read as idle for the whole time reset is held, not just after the edge.
    assign stall_o      = rst ? STALL_NONE : stall_merged;
    assign load_stall_o = !rst && load_hazard;
    assign mc_busy_o    = !rst && mc_busy;
    assign mc_done_o    = !rst && mc_done;

`ifdef STALL_PERF_CNT_EN
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] perf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_reg <= '0;
        end else if (stall_merged[0] && (perf_reg != '1)) begin
            perf_reg <= perf_reg + PERF_ONE;
        end
    end

    assign stall_cycles_o = rst ? '0 : perf_reg;
`else
    assign stall_cycles_o = '0;
`endif

endmodule
